// File: rtl/rx_cmd_pkg.sv
// Shared definitions for the serial command parser and the ALU it drives:
// FSM state encoding and the accepted opcode set.
package rx_cmd_pkg;

  localparam int unsigned StateW = 3;
  localparam int unsigned OpW    = 6;

  typedef enum logic [StateW-1:0] {
    StGetA   = 3'd0,
    StGetB   = 3'd1,
    StGetOp  = 3'd2,
    StCalc   = 3'd3,
    StSend   = 3'd4,
    StWaitTx = 3'd5
  } state_e;

  localparam logic [OpW-1:0] OpAdd = 6'b100000;
  localparam logic [OpW-1:0] OpSub = 6'b100010;
  localparam logic [OpW-1:0] OpAnd = 6'b100100;
  localparam logic [OpW-1:0] OpOr  = 6'b100101;
  localparam logic [OpW-1:0] OpXor = 6'b100110;
  localparam logic [OpW-1:0] OpNor = 6'b100111;
  localparam logic [OpW-1:0] OpSra = 6'b000011;
  localparam logic [OpW-1:0] OpSrl = 6'b000010;

  function automatic logic is_valid_op(input logic [OpW-1:0] op);
    return op inside {OpAdd, OpSub, OpAnd, OpOr, OpXor, OpNor, OpSra, OpSrl};
  endfunction

endpackage

// File: rtl/rx_cmd_timeout.sv
// Inter-byte timeout counter: counts while not cleared, holds once it reaches
// TIMEOUT_CYCLES-1 and flags o_expired.
module rx_cmd_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  output logic o_expired
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign o_expired = (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (!o_expired) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rx_cmd_parser.sv
// Parses A, B, opcode bytes from a UART receiver, drives an external ALU and
// hands the result to a UART transmitter. Define RX_CMD_TIMEOUT_EN for an inter-byte timeout.
module rx_cmd_parser
  import rx_cmd_pkg::*;
#(
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned OP_BITS        = 6,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_rx_done,
  input  logic [DATA_BITS-1:0] i_rx_data,
  input  logic [DATA_BITS-1:0] i_alu_result,
  input  logic                 i_tx_done,
  output logic [DATA_BITS-1:0] o_alu_a,
  output logic [DATA_BITS-1:0] o_alu_b,
  output logic [OP_BITS-1:0]   o_alu_op,
  output logic                 o_tx_start,
  output logic [DATA_BITS-1:0] o_tx_data,
  output logic                 o_busy,
  output logic                 o_err
);

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] a_q, a_d, b_q, b_d, tx_data_q, tx_data_d;
  logic [OP_BITS-1:0]   op_q, op_d;
  logic                 tx_start_q, tx_start_d, busy_q, busy_d, err_q, err_d;
  logic [OpW-1:0]       op_field;
  logic                 timeout_expired;

  assign op_field = OpW'(i_rx_data[OP_BITS-1:0]);

`ifdef RX_CMD_TIMEOUT_EN
  logic timeout_clear;

  // Counter only runs while waiting for B or the opcode.
  assign timeout_clear = i_rx_done || !(state_q == StGetB || state_q == StGetOp);

  rx_cmd_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clear  (timeout_clear),
    .o_expired(timeout_expired)
  );
`else
  assign timeout_expired = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      StGetA: begin
        if (i_rx_done) begin
          a_d     = i_rx_data;
          state_d = StGetB;
        end
      end
      StGetB: begin
        if (i_rx_done) begin
          b_d     = i_rx_data;
          state_d = StGetOp;
        end else if (timeout_expired) begin
          err_d   = 1'b1;
          state_d = StGetA;
        end
      end
      StGetOp: begin
        if (i_rx_done) begin
          if (is_valid_op(op_field)) begin
            op_d    = i_rx_data[OP_BITS-1:0];
            state_d = StCalc;
          end else begin
            err_d   = 1'b1;
            state_d = StGetA;
          end
        end else if (timeout_expired) begin
          err_d   = 1'b1;
          state_d = StGetA;
        end
      end
      StCalc: begin
        tx_data_d  = i_alu_result;
        tx_start_d = 1'b1;
        err_d      = i_rx_done;
        state_d    = StSend;
      end
      StSend: begin
        err_d   = i_rx_done;
        state_d = StWaitTx;
      end
      StWaitTx: begin
        // A byte arriving with i_tx_done is still an overrun and is dropped.
        err_d = i_rx_done;
        if (i_tx_done) begin
          state_d = StGetA;
        end
      end
      default: state_d = StGetA;
    endcase
    busy_d = (state_d == StCalc) || (state_d == StSend) || (state_d == StWaitTx);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= StGetA;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign o_alu_a    = a_q;
  assign o_alu_b    = b_q;
  assign o_alu_op   = op_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_busy     = busy_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_rx_cmd_parser.sv
// Self-checking bench for rx_cmd_parser: directed frames plus randomized frames
// checked against a frame-level model with a behavioural ALU.
module tb_rx_cmd_parser;

  localparam int unsigned Timeout = 100;

  logic       clk = 1'b0;
  logic       rst, rx_done, tx_done;
  logic [7:0] rx_data, alu_result;
  logic [7:0] o_alu_a, o_alu_b, o_tx_data;
  logic [5:0] o_alu_op;
  logic       o_tx_start, o_busy, o_err;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;
  int start_pulses = 0;

  // Model of the last values the parser should be holding.
  logic [7:0] m_a = 8'h00, m_b = 8'h00;
  logic [5:0] m_op = 6'h00;

  logic [5:0] valid_ops [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                6'b100110, 6'b100111, 6'b000011, 6'b000010};

  rx_cmd_parser #(
    .DATA_BITS     (8),
    .OP_BITS       (6),
    .TIMEOUT_CYCLES(Timeout)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_rx_done   (rx_done),
    .i_rx_data   (rx_data),
    .i_alu_result(alu_result),
    .i_tx_done   (tx_done),
    .o_alu_a     (o_alu_a),
    .o_alu_b     (o_alu_b),
    .o_alu_op    (o_alu_op),
    .o_tx_start  (o_tx_start),
    .o_tx_data   (o_tx_data),
    .o_busy      (o_busy),
    .o_err       (o_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_err) err_pulses++;
    if (o_tx_start) start_pulses++;
  end

  function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
    case (op)
      6'b100000: return a + b;
      6'b100010: return a - b;
      6'b100100: return a & b;
      6'b100101: return a | b;
      6'b100110: return a ^ b;
      6'b100111: return ~(a | b);
      6'b000011: return 8'($signed(a) >>> b);
      6'b000010: return a >> b;
      default:   return 8'h00;
    endcase
  endfunction

  function automatic bit op_valid(input logic [5:0] op);
    foreach (valid_ops[i]) if (valid_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  assign alu_result = alu_model(o_alu_a, o_alu_b, o_alu_op);

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Idle cycles, optionally with stray i_tx_done pulses that must be ignored.
  task automatic idle(input int n, input bit noise);
    repeat (n) begin
      tx_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      tick(1);
    end
    tx_done = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick(1);
    rx_done = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic do_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                          input bit finish_tx);
    int e0, s0;
    logic [7:0] exp;
    e0 = err_pulses;
    s0 = start_pulses;
    send_byte(a);
    idle($urandom_range(0, 3), 1'b1);
    send_byte(b);
    idle($urandom_range(0, 3), 1'b1);
    send_byte(opb);
    m_a = a;
    m_b = b;
    if (op_valid(opb[5:0])) begin
      m_op = opb[5:0];
      exp  = alu_model(a, b, opb[5:0]);
      checks++; if (o_alu_a !== a) begin errors++;
        $display("FAIL frame_a: got %h expected %h", o_alu_a, a); end
      checks++; if (o_alu_b !== b) begin errors++;
        $display("FAIL frame_b: got %h expected %h", o_alu_b, b); end
      checks++; if (o_alu_op !== opb[5:0]) begin errors++;
        $display("FAIL frame_op: got %h expected %h", o_alu_op, opb[5:0]); end
      checks++; if (o_busy !== 1'b1 || o_tx_start !== 1'b0) begin errors++;
        $display("FAIL calc_cycle: busy %b start %b expected 1 0", o_busy, o_tx_start); end
      tick(1);
      checks++; if (o_tx_start !== 1'b1) begin errors++;
        $display("FAIL tx_start_latency: got %b expected 1", o_tx_start); end
      checks++; if (o_tx_data !== exp) begin errors++;
        $display("FAIL tx_data: got %h expected %h (a %h b %h op %h)", o_tx_data, exp, a, b,
                 opb[5:0]); end
      tick(1);
      checks++; if (o_tx_start !== 1'b0 || o_busy !== 1'b1) begin errors++;
        $display("FAIL wait_tx: start %b busy %b expected 0 1", o_tx_start, o_busy); end
      if (finish_tx) begin
        idle($urandom_range(0, 4), 1'b0);
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
        checks++; if (o_busy !== 1'b0) begin errors++;
          $display("FAIL tx_done_return: busy %b expected 0", o_busy); end
      end
      checks++; if (start_pulses - s0 !== 1 || err_pulses - e0 !== 0) begin errors++;
        $display("FAIL frame_pulses: starts %0d errs %0d expected 1 0", start_pulses - s0,
                 err_pulses - e0); end
    end else begin
      checks++; if (o_err !== 1'b1 || o_busy !== 1'b0) begin errors++;
        $display("FAIL bad_op_err: err %b busy %b expected 1 0", o_err, o_busy); end
      checks++; if (o_alu_op !== m_op) begin errors++;
        $display("FAIL bad_op_hold: got %h expected %h", o_alu_op, m_op); end
      tick(1);
      checks++; if (o_err !== 1'b0) begin errors++;
        $display("FAIL bad_op_pulse_width: got %b expected 0", o_err); end
      idle(3, 1'b0);
      checks++; if (start_pulses != s0 || err_pulses - e0 != 1) begin errors++;
        $display("FAIL bad_op_pulses: starts %0d errs %0d expected 0 1", start_pulses - s0,
                 err_pulses - e0); end
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_busy, o_err} !== '0) begin
      errors++;
      $display("FAIL %s: a %h b %h op %h tx %h start %b busy %b err %b expected all 0", tag,
               o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_busy, o_err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_done = 1'b0; tx_done = 1'b0; rx_data = 8'h00;
    tick(3);
    check_all_zero("reset_held");
    rst = 1'b0;
    tick(2);
    check_all_zero("reset_release");
  endtask

  task automatic test_known_frames();
    do_frame(8'h05, 8'h03, 8'h20, 1'b1);
    do_frame(8'h0F, 8'h01, 8'h3F, 1'b1);
    do_frame(8'hF0, 8'h0F, 8'h25, 1'b1);
    checks++; if (o_tx_data !== 8'hFF) begin errors++;
      $display("FAIL or_frame_result: got %h expected ff", o_tx_data); end
  endtask

  task automatic test_random_frames();
    logic [7:0] opb;
    for (int i = 0; i < 40; i++) begin
      opb = 8'($urandom);
      if ($urandom_range(0, 3) != 0) opb[5:0] = valid_ops[$urandom_range(0, 7)];
      do_frame(8'($urandom), 8'($urandom), opb, 1'b1);
    end
  endtask

  task automatic test_overrun();
    int e0;
    do_frame(8'h12, 8'h34, 8'h26, 1'b0);
    e0 = err_pulses;
    send_byte(8'hAA);
    checks++; if (o_err !== 1'b1 || o_busy !== 1'b1) begin errors++;
      $display("FAIL overrun_err: err %b busy %b expected 1 1", o_err, o_busy); end
    checks++; if (o_alu_a !== m_a) begin errors++;
      $display("FAIL overrun_a: got %h expected %h", o_alu_a, m_a); end
    tick(1);
    // Byte and i_tx_done together: leave WAIT_TX, byte dropped as overrun.
    rx_data = 8'h55; rx_done = 1'b1; tx_done = 1'b1;
    tick(1);
    rx_done = 1'b0; tx_done = 1'b0;
    checks++; if (o_err !== 1'b1 || o_busy !== 1'b0) begin errors++;
      $display("FAIL simul_rx_tx: err %b busy %b expected 1 0", o_err, o_busy); end
    checks++; if (o_alu_a !== m_a || err_pulses - e0 != 1) begin errors++;
      $display("FAIL simul_a: a %h errs %0d expected %h 1", o_alu_a, err_pulses - e0, m_a); end
    tick(1);
    do_frame(8'h07, 8'h02, 8'h22, 1'b1);
  endtask

  task automatic test_reset_mid();
    int s0;
    send_byte(8'h05);
    send_byte(8'h03);
    rst = 1'b1; tick(1); rst = 1'b0;
    check_all_zero("reset_mid_frame");
    m_a = 8'h00; m_b = 8'h00; m_op = 6'h00;
    send_byte(8'h20);
    checks++; if (o_alu_a !== 8'h20 || o_alu_b !== 8'h00) begin errors++;
      $display("FAIL reset_operand_a: a %h b %h expected 20 00", o_alu_a, o_alu_b); end
    send_byte(8'h0C);
    s0 = start_pulses;
    send_byte(8'h24);
    rst = 1'b1; tick(1); rst = 1'b0;
    idle(5, 1'b0);
    checks++; if (start_pulses != s0 || o_tx_data !== 8'h00) begin errors++;
      $display("FAIL reset_in_calc: starts %0d tx %h expected 0 00", start_pulses - s0,
               o_tx_data); end
    m_a = 8'h00; m_b = 8'h00; m_op = 6'h00;
    do_frame(8'h81, 8'h02, 8'h03, 1'b1);
  endtask

  task automatic test_idle_timeout();
    int e0;
    send_byte(8'h05);
    e0 = err_pulses;
    idle(1000, 1'b0);
`ifdef RX_CMD_TIMEOUT_EN
    checks++; if (err_pulses - e0 != 1) begin errors++;
      $display("FAIL timeout_err: got %0d pulses expected 1", err_pulses - e0); end
`else
    checks++; if (err_pulses - e0 != 0) begin errors++;
      $display("FAIL no_timeout: got %0d pulses expected 0", err_pulses - e0); end
    send_byte(8'h03);
    send_byte(8'h21);
    idle(5, 1'b0);
    rst = 1'b1; tick(1); rst = 1'b0;
    m_a = 8'h00; m_b = 8'h00; m_op = 6'h00;
`endif
    do_frame(8'h33, 8'h0F, 8'h27, 1'b1);
  endtask

  initial begin
    test_reset();
    test_known_frames();
    test_random_frames();
    test_overrun();
    test_reset_mid();
    test_idle_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
